// File: rtl/deck_dealer.sv
// ============================================================================
// deck_dealer
// ----------------------------------------------------------------------------
// Sequences the card shuffler and serves dealt cards to the blackjack
// datapath. A shuffle is started, the 52 cards the shuffler streams back are
// buffered, and draw requests from the player and dealer paths are
// arbitrated round-robin. Each dealt card comes with its blackjack points.
// A reshuffle is requested automatically when the deck empties, or at a hand
// boundary when the deck has run low.
//
// Optional feature (macro HILO_COUNT_EN):
//   adds hilo_count [6:0], a two's complement running hi-lo count of dealt
//   cards, cleared at every shuffle.
//
// Ports:
//   clk, rst            clock (posedge), asynchronous active-high reset
//   start, seed_in      begin the first shuffle with the given base seed
//   shuf_start          level to shuffler, high through SHUF and LOAD
//   shuf_seed           seed presented to the shuffler
//   ld_valid, ld_card   card stream from the shuffler
//   req_p, req_d        player / dealer draw requests (level)
//   ack_p, ack_d        one-cycle grants; card_out/card_pts valid with them
//   card_out, card_pts  dealt card id and its point value
//   remaining           undealt cards in the buffer
//   ready               deck available (READY/ACK)
//   new_hand            hand boundary pulse, triggers the low-deck check
//   load_err            sticky load failure (timeout or bad card id)
// ============================================================================
module deck_dealer #(
    parameter int DECK_SIZE     = 52,
    parameter int RESHUF_THRESH = 15,
    parameter int LOAD_TIMEOUT  = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [5:0] seed_in,
    output logic       shuf_start,
    output logic [5:0] shuf_seed,
    input  logic       ld_valid,
    input  logic [5:0] ld_card,
    input  logic       req_p,
    input  logic       req_d,
    output logic       ack_p,
    output logic       ack_d,
    output logic [5:0] card_out,
    output logic [3:0] card_pts,
    output logic [5:0] remaining,
    output logic       ready,
    input  logic       new_hand,
`ifdef HILO_COUNT_EN
    output logic [6:0] hilo_count,
`endif
    output logic       load_err
);

    localparam int TW = $clog2(LOAD_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, SHUF, LOAD, READY, ACK} state_t;

    state_t        state_reg;
    logic [5:0]    deck_mem [DECK_SIZE];
    logic [5:0]    wr_ptr_reg;
    logic [5:0]    rd_ptr_reg;
    logic [TW-1:0] idle_cnt_reg;   // LOAD cycles since the last ld_valid
    logic          rr_dealer_reg;  // 1 = dealer was served last

    // Blackjack points of a card id: rank 0 is the ace.
    function automatic logic [3:0] card_points(input logic [5:0] id);
        logic [5:0] r;
        r = id % 6'd13;
        if (r == 6'd0)      return 4'd1;
        else if (r <= 6'd9) return 4'(r) + 4'd1;
        else                return 4'd10;
    endfunction

    // The buffer is dealt as a stack: the last card loaded is the first card
    // dealt. rd_ptr counts cards dealt from the top.
    logic [5:0] rd_addr;
    logic [5:0] rd_card;
    logic [3:0] rd_pts;
    assign rd_addr = 6'(DECK_SIZE - 1) - rd_ptr_reg;
    assign rd_card = deck_mem[rd_addr];
    assign rd_pts  = card_points(rd_card);

    // Round-robin: on a tie the side not served last wins.
    logic grant_p, grant_d;
    assign grant_p = req_p && (!req_d || rr_dealer_reg);
    assign grant_d = req_d && (!req_p || !rr_dealer_reg);

    logic ld_bad;
    assign ld_bad = ld_card >= 6'(DECK_SIZE);

    // Card buffer; only valid ids reach it.
    always_ff @(posedge clk) begin
        if (state_reg == LOAD && ld_valid && !ld_bad)
            deck_mem[wr_ptr_reg] <= ld_card;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            shuf_start    <= 1'b0;
            shuf_seed     <= 6'd0;
            ack_p         <= 1'b0;
            ack_d         <= 1'b0;
            card_out      <= 6'd0;
            card_pts      <= 4'd0;
            remaining     <= 6'd0;
            ready         <= 1'b0;
            load_err      <= 1'b0;
            wr_ptr_reg    <= 6'd0;
            rd_ptr_reg    <= 6'd0;
            idle_cnt_reg  <= '0;
            rr_dealer_reg <= 1'b1;
`ifdef HILO_COUNT_EN
            hilo_count    <= 7'd0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        shuf_seed    <= seed_in;
                        load_err     <= 1'b0;
                        idle_cnt_reg <= '0;
                        shuf_start   <= 1'b1;
                        state_reg    <= SHUF;
                    end
                end
                SHUF: begin
                    wr_ptr_reg   <= 6'd0;
                    remaining    <= 6'd0;
                    idle_cnt_reg <= '0;
`ifdef HILO_COUNT_EN
                    hilo_count   <= 7'd0;
`endif
                    state_reg    <= LOAD;
                end
                LOAD: begin
                    if (ld_valid && ld_bad) begin
                        load_err   <= 1'b1;
                        shuf_start <= 1'b0;
                        state_reg  <= IDLE;
                    end else if (ld_valid) begin
                        wr_ptr_reg   <= wr_ptr_reg + 6'd1;
                        idle_cnt_reg <= '0;
                        if (wr_ptr_reg == 6'(DECK_SIZE - 1)) begin
                            shuf_start <= 1'b0;
                            rd_ptr_reg <= 6'd0;
                            remaining  <= 6'(DECK_SIZE);
                            ready      <= 1'b1;
                            state_reg  <= READY;
                        end
                    end else if (idle_cnt_reg == TW'(LOAD_TIMEOUT - 1)) begin
                        load_err   <= 1'b1;
                        shuf_start <= 1'b0;
                        state_reg  <= IDLE;
                    end else begin
                        idle_cnt_reg <= idle_cnt_reg + 1'b1;
                    end
                end
                READY: begin
                    // Priority: empty deck, then grant, then new_hand check.
                    if (remaining == 6'd0) begin
                        shuf_seed  <= shuf_seed + 6'd1;
                        shuf_start <= 1'b1;
                        ready      <= 1'b0;
                        state_reg  <= SHUF;
                    end else if (grant_p || grant_d) begin
                        card_out      <= rd_card;
                        card_pts      <= rd_pts;
                        rd_ptr_reg    <= rd_ptr_reg + 6'd1;
                        remaining     <= remaining - 6'd1;
                        ack_p         <= grant_p;
                        ack_d         <= grant_d;
                        rr_dealer_reg <= grant_d;
`ifdef HILO_COUNT_EN
                        if (rd_pts >= 4'd2 && rd_pts <= 4'd6)
                            hilo_count <= hilo_count + 7'd1;
                        else if (rd_pts == 4'd10 || rd_pts == 4'd1)
                            hilo_count <= hilo_count - 7'd1;
`endif
                        state_reg     <= ACK;
                    end else if (new_hand && remaining < 6'(RESHUF_THRESH)) begin
                        shuf_seed  <= shuf_seed + 6'd1;
                        shuf_start <= 1'b1;
                        ready      <= 1'b0;
                        state_reg  <= SHUF;
                    end
                end
                ACK: begin
                    ack_p     <= 1'b0;
                    ack_d     <= 1'b0;
                    state_reg <= READY;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_deck_dealer.sv
// Randomized bench for deck_dealer with a card-level reference model:
// the loaded deck is kept as an array dealt from the top, the arbiter is
// modelled by "who was served last", and seeds/points are plain arithmetic.
module tb_deck_dealer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [5:0] seed_in = 6'd0;
    logic       shuf_start;
    logic [5:0] shuf_seed;
    logic       ld_valid = 1'b0;
    logic [5:0] ld_card = 6'd0;
    logic       req_p = 1'b0;
    logic       req_d = 1'b0;
    logic       ack_p, ack_d;
    logic [5:0] card_out;
    logic [3:0] card_pts;
    logic [5:0] remaining;
    logic       ready;
    logic       new_hand = 1'b0;
    logic       load_err;
`ifdef HILO_COUNT_EN
    logic [6:0] hilo_count;
`endif

    deck_dealer dut (
        .clk(clk), .rst(rst), .start(start), .seed_in(seed_in),
        .shuf_start(shuf_start), .shuf_seed(shuf_seed),
        .ld_valid(ld_valid), .ld_card(ld_card),
        .req_p(req_p), .req_d(req_d), .ack_p(ack_p), .ack_d(ack_d),
        .card_out(card_out), .card_pts(card_pts), .remaining(remaining),
        .ready(ready), .new_hand(new_hand),
`ifdef HILO_COUNT_EN
        .hilo_count(hilo_count),
`endif
        .load_err(load_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int deck [52];
    int m_rem;
    int m_seed;
    bit m_rr_dealer;
    int m_hilo;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int pts_of(input int id);
        int r;
        r = id % 13;
        if (r == 0) return 1;
        if (r <= 9) return r + 1;
        return 10;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shuffle_deck();
        for (int i = 0; i < 52; i++) deck[i] = i;
        for (int i = 51; i > 0; i--) begin
            int j, t;
            j = $urandom_range(0, i);
            t = deck[i]; deck[i] = deck[j]; deck[j] = t;
        end
    endtask

    task automatic do_start(input int seed);
        seed_in = 6'(seed);
        start = 1'b1;
        tick();
        start = 1'b0;
        m_seed = seed;
        m_hilo = 0;
        check_val("start shuf_start", 32'(shuf_start), 1);
        check_val("start shuf_seed", 32'(shuf_seed), 32'(m_seed));
        check_val("start load_err", 32'(load_err), 0);
        $display("start seed=%0d", seed);
    endtask

    // Called in the SHUF cycle; streams the first n cards of deck[].
    task automatic load_deck(input int n, input bit gaps);
        tick();
        m_hilo = 0;
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            ld_valid = 1'b1;
            ld_card  = 6'(deck[i]);
            tick();
            ld_valid = 1'b0;
        end
        if (n == 52) begin
            m_rem = 52;
            check_val("load ready", 32'(ready), 1);
            check_val("load remaining", 32'(remaining), 52);
            check_val("load shuf_start", 32'(shuf_start), 0);
        end
        $display("loaded %0d cards", n);
    endtask

    task automatic check_grant(input bit p, input bit d);
        bit exp_p;
        exp_p = p && (!d || m_rr_dealer);
        check_val("ack_p", 32'(ack_p), 32'(exp_p));
        check_val("ack_d", 32'(ack_d), 32'(!exp_p));
        check_val("card_out", 32'(card_out), 32'(deck[m_rem-1]));
        check_val("card_pts", 32'(card_pts), 32'(pts_of(deck[m_rem-1])));
        check_val("remaining", 32'(remaining), 32'(m_rem - 1));
        m_rr_dealer = !exp_p;
        if (pts_of(deck[m_rem-1]) >= 2 && pts_of(deck[m_rem-1]) <= 6) m_hilo++;
        else if (pts_of(deck[m_rem-1]) == 10 || pts_of(deck[m_rem-1]) == 1) m_hilo--;
`ifdef HILO_COUNT_EN
        begin
            logic [6:0] h;
            h = 7'(m_hilo);
            check_val("hilo_count", 32'(hilo_count), 32'(h));
        end
`endif
        $display("grant %s card=%0d pts=%0d rem=%0d", exp_p ? "player" : "dealer",
                 card_out, card_pts, remaining);
        m_rem--;
    endtask

    task automatic draw(input bit p, input bit d);
        int waited;
        req_p = p;
        req_d = d;
        waited = 0;
        do begin
            tick();
            waited++;
        end while (!(ack_p || ack_d) && waited < 8);
        req_p = 1'b0;
        req_d = 1'b0;
        if (!(ack_p || ack_d)) check_val("ack timeout", 0, 1);
        else check_grant(p, d);
    endtask

    task automatic pulse_new_hand();
        tick();           // ACK -> READY
        new_hand = 1'b1;
        tick();
        new_hand = 1'b0;
    endtask

    initial begin
        m_rr_dealer = 1'b1;
        repeat (3) tick();
        check_val("rst shuf_start", 32'(shuf_start), 0);
        check_val("rst ready", 32'(ready), 0);
        check_val("rst remaining", 32'(remaining), 0);
        check_val("rst card_out", 32'(card_out), 0);
        check_val("rst ack", 32'({ack_p, ack_d}), 0);
        rst = 1'b0;
        tick();

        // Ordered deck, seed 43
        for (int i = 0; i < 52; i++) deck[i] = i;
        do_start(43);
        load_deck(52, 1'b1);
        draw(1'b1, 1'b0);   // top card is id 51

        // Both requests held: one grant every other cycle, alternating
        tick();
        req_p = 1'b1;
        req_d = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (k % 2 == 0) check_grant(1'b1, 1'b1);
            else check_val("held idle cycle", 32'({ack_p, ack_d}), 0);
        end
        req_p = 1'b0;
        req_d = 1'b0;

        // Random draws down to 15 remaining
        while (m_rem > 15) begin
            int r;
            r = $urandom_range(1, 3);
            draw(r[0], r[1]);
        end
        pulse_new_hand();
        check_val("thresh15 shuf_start", 32'(shuf_start), 0);
        check_val("thresh15 ready", 32'(ready), 1);
        draw(1'b0, 1'b1);
        pulse_new_hand();
        m_seed = (m_seed + 1) % 64;
        check_val("thresh14 shuf_start", 32'(shuf_start), 1);
        check_val("thresh14 seed", 32'(shuf_seed), 32'(m_seed));
        check_val("thresh14 ready", 32'(ready), 0);

        // Shuffled deck, deal to empty, auto reshuffle
        shuffle_deck();
        load_deck(52, 1'b1);
        while (m_rem > 0) begin
            int r;
            r = $urandom_range(1, 3);
            draw(r[0], r[1]);
        end
        req_p = 1'b1;
        tick();
        check_val("empty no ack", 32'({ack_p, ack_d}), 0);
        tick();
        m_seed = (m_seed + 1) % 64;
        check_val("empty no ack2", 32'({ack_p, ack_d}), 0);
        check_val("empty reshuf", 32'(shuf_start), 1);
        check_val("empty seed", 32'(shuf_seed), 32'(m_seed));
        req_p = 1'b0;

        // Load timeout
        load_deck(5, 1'b0);
        repeat (63) tick();
        check_val("timeout early", 32'(load_err), 0);
        tick();
        check_val("timeout load_err", 32'(load_err), 1);
        check_val("timeout shuf_start", 32'(shuf_start), 0);
        $display("load timeout seen");

        // Bad card id
        do_start(7);
        load_deck(3, 1'b0);
        ld_valid = 1'b1;
        ld_card  = 6'd52;
        tick();
        ld_valid = 1'b0;
        check_val("badid load_err", 32'(load_err), 1);
        check_val("badid shuf_start", 32'(shuf_start), 0);

        // Reset during load
        do_start(20);
        load_deck(20, 1'b0);
        rst = 1'b1;
        tick();
        check_val("midrst shuf_start", 32'(shuf_start), 0);
        check_val("midrst seed", 32'(shuf_seed), 0);
        check_val("midrst ready", 32'(ready), 0);
        check_val("midrst card_out", 32'(card_out), 0);
        rst = 1'b0;
        m_rr_dealer = 1'b1;
        tick();

        // Deck with id 1 on top then id 0 (hi-lo +1 then back to 0)
        shuffle_deck();
        for (int i = 0; i < 52; i++) begin
            if (deck[i] == 1) begin deck[i] = deck[51]; deck[51] = 1; end
        end
        for (int i = 0; i < 51; i++) begin
            if (deck[i] == 0) begin deck[i] = deck[50]; deck[50] = 0; end
        end
        do_start(9);
        load_deck(52, 1'b0);
        draw(1'b0, 1'b1);
        draw(1'b1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            int r;
            r = $urandom_range(1, 3);
            draw(r[0], r[1]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
